// File: rtl/mc_pkg.sv
// Shared encodings and field widths for the mc_rq_*/mc_rs_* memory-controller interface.
// Used by the responder and by the initiating cores.
package mc_pkg;

    localparam int MC_CMD_W  = 3;
    localparam int MC_SCMD_W = 4;
    localparam int MC_VADR_W = 48;
    localparam int MC_SIZE_W = 2;
    localparam int MC_DATA_W = 64;

    localparam logic [MC_CMD_W-1:0] MC_CMD_RD = 3'd1;
    localparam logic [MC_CMD_W-1:0] MC_CMD_WR = 3'd2;

    localparam logic [MC_CMD_W-1:0] MC_RS_RD_DATA     = 3'd2;
    localparam logic [MC_CMD_W-1:0] MC_RS_WR_CMPLT    = 3'd3;
    localparam logic [MC_CMD_W-1:0] MC_RS_FLUSH_CMPLT = 3'd4;

    localparam logic [MC_SIZE_W-1:0] MC_SIZE_1B = 2'd0;
    localparam logic [MC_SIZE_W-1:0] MC_SIZE_2B = 2'd1;
    localparam logic [MC_SIZE_W-1:0] MC_SIZE_4B = 2'd2;
    localparam logic [MC_SIZE_W-1:0] MC_SIZE_8B = 2'd3;

    typedef enum logic [1:0] {
        OP_RD    = 2'd0,
        OP_WR    = 2'd1,
        OP_FLUSH = 2'd2
    } mc_op_e;

    // Lanes that spill past byte 7 are dropped rather than wrapping into the next word.
    function automatic logic [7:0] mc_byte_en(input logic [MC_SIZE_W-1:0] size,
                                              input logic [2:0] ofs);
        logic [15:0] m;
        m = (16'd1 << (4'd1 << size)) - 16'd1;
        m = m << ofs;
        return m[7:0];
    endfunction

endpackage

// File: rtl/mc_responder_if.sv
// Request/response bundle between an initiator (master) and the memory-controller responder (slave).
interface mc_responder_if #(
    parameter int MC_RTNCTL_WIDTH = 32
);
    import mc_pkg::*;

    // Requests: accepted on every cycle mc_rq_vld=1; mc_rq_stall is advisory and lags by one cycle.
    // Responses: transfer on a cycle with mc_rs_vld=1 and mc_rs_stall=0; payload holds while stalled.
    logic                       mc_rq_vld;
    logic [MC_CMD_W-1:0]        mc_rq_cmd;
    logic [MC_SCMD_W-1:0]       mc_rq_scmd;
    logic [MC_VADR_W-1:0]       mc_rq_vadr;
    logic [MC_SIZE_W-1:0]       mc_rq_size;
    logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
    logic [MC_DATA_W-1:0]       mc_rq_data;
    logic                       mc_rq_flush;
    logic                       mc_rq_stall;
    logic                       mc_rs_vld;
    logic [MC_CMD_W-1:0]        mc_rs_cmd;
    logic [MC_SCMD_W-1:0]       mc_rs_scmd;
    logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
    logic [MC_DATA_W-1:0]       mc_rs_data;
    logic                       mc_rs_stall;

    modport master (
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
    );

    modport slave (
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is visible on pop_data the cycle after its push.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int NB_DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    pop_data,
    output logic                full,
    output logic                empty,
    output logic [NB_DEPTH:0]   count
);
    localparam int DEPTH = 1 << NB_DEPTH;
    localparam int CW    = NB_DEPTH + 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [NB_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + NB_DEPTH'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + NB_DEPTH'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mc_responder.sv
// Memory-controller responder: request FIFO -> word array + fixed-latency pipe -> response FIFO.
// Responses leave strictly in acceptance order; the array itself is never reset.
module mc_responder
    import mc_pkg::*;
#(
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int NB_MEM          = 8,
    parameter int LATENCY         = 4,
    parameter int NB_RQ_DEPTH     = 3,
    parameter int NB_RS_DEPTH     = 3,
    parameter int STALL_MARGIN    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_responder_if.slave bus,
    output logic [15:0]   err_cnt
);
    localparam int CNT_W = 16;

    typedef struct packed {
        mc_op_e                     op;
        logic [MC_SCMD_W-1:0]       scmd;
        logic [NB_MEM-1:0]          idx;
        logic [2:0]                 ofs;
        logic [MC_SIZE_W-1:0]       size;
        logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
        logic [MC_DATA_W-1:0]       data;
    } rq_ent_t;

    typedef struct packed {
        logic [MC_CMD_W-1:0]        cmd;
        logic [MC_SCMD_W-1:0]       scmd;
        logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
        logic [MC_DATA_W-1:0]       data;
    } rs_ent_t;

    typedef struct packed {
        logic    vld;
        rs_ent_t rs;
    } pipe_ent_t;

    rq_ent_t              rq_in, rq_head;
    logic                 rq_legal, rq_push, rq_pop, rq_full, rq_empty;
    logic [NB_RQ_DEPTH:0] rq_count;
    rs_ent_t              rs_head, rs_out;
    logic                 rs_push, rs_pop, rs_empty, unused_rs_full;
    logic [NB_RS_DEPTH:0] rs_count;
    logic [CNT_W-1:0]     rq_free, rs_free, inflight;
    pipe_ent_t            pipe_q [LATENCY];
    pipe_ent_t            pipe_d [LATENCY];
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic                 stall_q, stall_d;
    logic [MC_DATA_W-1:0] mem [1 << NB_MEM];
    logic                 wr_en;
    logic [7:0]           wr_be;
    logic                 unused_vadr;

    assign unused_vadr = ^bus.mc_rq_vadr[MC_VADR_W-1:3+NB_MEM];

    always_comb begin
        rq_legal     = bus.mc_rq_flush || (bus.mc_rq_cmd == MC_CMD_RD) || (bus.mc_rq_cmd == MC_CMD_WR);
        rq_in        = '0;
        rq_in.op     = bus.mc_rq_flush ? OP_FLUSH : ((bus.mc_rq_cmd == MC_CMD_WR) ? OP_WR : OP_RD);
        rq_in.scmd   = bus.mc_rq_scmd;
        rq_in.idx    = bus.mc_rq_vadr[3 +: NB_MEM];
        rq_in.ofs    = bus.mc_rq_vadr[2:0];
        rq_in.size   = bus.mc_rq_size;
        rq_in.rtnctl = bus.mc_rq_rtnctl;
        rq_in.data   = bus.mc_rq_data;

        // Only issue when the response FIFO can absorb everything already in the pipe plus this one.
        rq_free  = CNT_W'(1 << NB_RQ_DEPTH) - CNT_W'(rq_count);
        rs_free  = CNT_W'(1 << NB_RS_DEPTH) - CNT_W'(rs_count);
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + CNT_W'(pipe_q[i].vld);
        rq_pop   = !rq_empty && (rs_free > inflight);
        rq_push  = bus.mc_rq_vld && rq_legal && (!rq_full || rq_pop);

        err_cnt_d = err_cnt_q;
        if (bus.mc_rq_vld && !rq_push && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
        stall_d = (rq_free <= CNT_W'(STALL_MARGIN));
    end

    sync_fifo #(.WIDTH($bits(rq_ent_t)), .NB_DEPTH(NB_RQ_DEPTH)) u_rq_fifo (
        .clk(clk), .rst_n(rst_n), .push(rq_push), .push_data(rq_in), .pop(rq_pop),
        .pop_data(rq_head), .full(rq_full), .empty(rq_empty), .count(rq_count)
    );

    always_comb begin
        wr_en = rq_pop && (rq_head.op == OP_WR);
        wr_be = mc_byte_en(rq_head.size, rq_head.ofs);

        pipe_d[0]           = '0;
        pipe_d[0].vld       = rq_pop;
        pipe_d[0].rs.scmd   = rq_head.scmd;
        pipe_d[0].rs.rtnctl = rq_head.rtnctl;
        case (rq_head.op)
            OP_RD: begin
                pipe_d[0].rs.cmd  = MC_RS_RD_DATA;
                pipe_d[0].rs.data = mem[rq_head.idx];
            end
            OP_WR:   pipe_d[0].rs.cmd = MC_RS_WR_CMPLT;
            default: pipe_d[0].rs.cmd = MC_RS_FLUSH_CMPLT;
        endcase
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) mem[rq_head.idx][8*b +: 8] <= rq_head.data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            err_cnt_q <= '0;
            stall_q   <= 1'b0;
        end else begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
            err_cnt_q <= err_cnt_d;
            stall_q   <= stall_d;
        end
    end

    assign rs_push = pipe_q[LATENCY-1].vld;
    assign rs_pop  = !rs_empty && !bus.mc_rs_stall;

    sync_fifo #(.WIDTH($bits(rs_ent_t)), .NB_DEPTH(NB_RS_DEPTH)) u_rs_fifo (
        .clk(clk), .rst_n(rst_n), .push(rs_push), .push_data(pipe_q[LATENCY-1].rs), .pop(rs_pop),
        .pop_data(rs_head), .full(unused_rs_full), .empty(rs_empty), .count(rs_count)
    );

    // FIFO storage is not reset, so the payload is gated to read as zero while empty.
    assign rs_out           = rs_empty ? '0 : rs_head;
    assign bus.mc_rs_vld    = !rs_empty;
    assign bus.mc_rs_cmd    = rs_out.cmd;
    assign bus.mc_rs_scmd   = rs_out.scmd;
    assign bus.mc_rs_rtnctl = rs_out.rtnctl;
    assign bus.mc_rs_data   = rs_out.data;
    assign bus.mc_rq_stall  = stall_q;
    assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_mc_responder.sv
// Directed bench for mc_responder: write/read, byte lanes, backpressure, illegal cmd, flush, reset.
module tb_mc_responder;
    localparam int LAT_EXP = 5;
    localparam int W       = 103;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] err_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_cyc_q[$];

    mc_responder_if #(.MC_RTNCTL_WIDTH(32)) bus();

    mc_responder #(
        .MC_RTNCTL_WIDTH(32), .NB_MEM(8), .LATENCY(4),
        .NB_RQ_DEPTH(3), .NB_RS_DEPTH(3), .STALL_MARGIN(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.mc_rs_vld && !bus.mc_rs_stall) begin
            got_q.push_back({bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_rtnctl, bus.mc_rs_data});
            got_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1);
    end

    task automatic send(input logic [2:0] cmd, input logic flush, input logic [47:0] vadr,
                        input logic [1:0] size, input logic [31:0] tag, input logic [63:0] data,
                        input logic [3:0] scmd, output int acc_cyc);
        int guard = 0;
        while (bus.mc_rq_stall && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL send_stall_timeout: stall held %0d cycles, required release", guard);
        end
        bus.mc_rq_vld    = 1'b1;
        bus.mc_rq_cmd    = cmd;
        bus.mc_rq_flush  = flush;
        bus.mc_rq_vadr   = vadr;
        bus.mc_rq_size   = size;
        bus.mc_rq_rtnctl = tag;
        bus.mc_rq_data   = data;
        bus.mc_rq_scmd   = scmd;
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        bus.mc_rq_vld   = 1'b0;
        bus.mc_rq_flush = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (6) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.mc_rs_vld, bus.mc_rq_stall, err_cnt} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %h required 0", {bus.mc_rs_vld, bus.mc_rq_stall, err_cnt});
        end
        n_cmp++;
        if ({bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_rtnctl, bus.mc_rs_data} !== '0) begin
            n_err++;
            $display("FAIL reset_payload: got %h required 0",
                     {bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_rtnctl, bus.mc_rs_data});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.mc_rs_vld, bus.mc_rq_stall} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release: got %b required 00", {bus.mc_rs_vld, bus.mc_rq_stall});
        end
    endtask

    task automatic test_wr_rd();
        int a0, a1, g0, g1;
        logic [W-1:0] e, g;
        send(3'd2, 1'b0, 48'h40, 2'd3, 32'd7, 64'hDEADBEEF_CAFEF00D, 4'h1, a0);
        send(3'd1, 1'b0, 48'h40, 2'd3, 32'd8, 64'd0, 4'h2, a1);
        exp_q.push_back({3'd3, 4'h1, 32'd7, 64'd0});
        exp_q.push_back({3'd2, 4'h2, 32'd8, 64'hDEADBEEF_CAFEF00D});
        wait_resp(2, 100);
        n_cmp++;
        if (got_q.size() !== 2) begin
            n_err++;
            $display("FAIL wrrd_count: got %0d required 2", got_q.size());
        end
        if (got_cyc_q.size() >= 2) begin
            g0 = got_cyc_q[0];
            g1 = got_cyc_q[1];
            n_cmp++;
            if (g0 - a0 !== LAT_EXP) begin
                n_err++;
                $display("FAIL wrrd_lat_wr: got %0d required %0d", g0 - a0, LAT_EXP);
            end
            n_cmp++;
            if (g1 - a1 !== LAT_EXP) begin
                n_err++;
                $display("FAIL wrrd_lat_rd: got %0d required %0d", g1 - a1, LAT_EXP);
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL wrrd_resp: got %h required %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_byte_lanes();
        int a;
        logic [W-1:0] e, g;
        send(3'd2, 1'b0, 48'h40, 2'd3, 32'd10, 64'hFFFFFFFF_FFFFFFFF, 4'h0, a);
        send(3'd2, 1'b0, 48'h43, 2'd0, 32'd11, 64'h00000000_AB000000, 4'h0, a);
        send(3'd1, 1'b0, 48'h40, 2'd3, 32'd12, 64'd0, 4'h3, a);
        send(3'd2, 1'b0, 48'h48, 2'd3, 32'd13, 64'hFFFFFFFF_FFFFFFFF, 4'h0, a);
        send(3'd2, 1'b0, 48'h4E, 2'd2, 32'd14, 64'h11223344_55667788, 4'h0, a);
        send(3'd1, 1'b0, 48'h48, 2'd3, 32'd15, 64'd0, 4'h5, a);
        send(3'd1, 1'b0, 48'h8000_0000_0840, 2'd3, 32'd16, 64'd0, 4'h6, a);
        exp_q.push_back({3'd3, 4'h0, 32'd10, 64'd0});
        exp_q.push_back({3'd3, 4'h0, 32'd11, 64'd0});
        exp_q.push_back({3'd2, 4'h3, 32'd12, 64'hFFFFFFFF_ABFFFFFF});
        exp_q.push_back({3'd3, 4'h0, 32'd13, 64'd0});
        exp_q.push_back({3'd3, 4'h0, 32'd14, 64'd0});
        exp_q.push_back({3'd2, 4'h5, 32'd15, 64'h1122FFFF_FFFFFFFF});
        exp_q.push_back({3'd2, 4'h6, 32'd16, 64'hFFFFFFFF_ABFFFFFF});
        wait_resp(7, 100);
        n_cmp++;
        if (got_q.size() !== 7) begin
            n_err++;
            $display("FAIL lanes_count: got %0d required 7", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL lanes_resp: got %h required %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_back_to_back_stall();
        logic         saw_stall = 1'b0;
        logic [103:0] snap;
        logic [W-1:0] e, g;
        bus.mc_rs_stall = 1'b1;
        for (int i = 0; i < 20; i++) exp_q.push_back({3'd2, 4'(i), 32'(100 + i), 64'hFFFFFFFF_ABFFFFFF});
        fork
            begin
                int a;
                for (int i = 0; i < 20; i++) send(3'd1, 1'b0, 48'h40, 2'd3, 32'(100 + i), 64'd0, 4'(i), a);
            end
            begin
                repeat (30) begin
                    @(posedge clk); #1;
                    if (bus.mc_rq_stall) saw_stall = 1'b1;
                end
                snap = {bus.mc_rs_vld, bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_rtnctl, bus.mc_rs_data};
                repeat (10) @(posedge clk);
                #1;
                n_cmp++;
                if (saw_stall !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_asserted: got %b required 1", saw_stall);
                end
                n_cmp++;
                if ({bus.mc_rs_vld, bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_rtnctl, bus.mc_rs_data} !== snap) begin
                    n_err++;
                    $display("FAIL stall_stable: got %h required %h",
                             {bus.mc_rs_vld, bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_rtnctl, bus.mc_rs_data}, snap);
                end
                n_cmp++;
                if ({bus.mc_rs_vld, bus.mc_rs_rtnctl} !== {1'b1, 32'd100}) begin
                    n_err++;
                    $display("FAIL stall_head: got vld=%b tag=%0d required vld=1 tag=100",
                             bus.mc_rs_vld, bus.mc_rs_rtnctl);
                end
                n_cmp++;
                if (got_q.size() !== 0) begin
                    n_err++;
                    $display("FAIL stall_no_xfer: got %0d responses required 0", got_q.size());
                end
                bus.mc_rs_stall = 1'b0;
            end
        join
        wait_resp(20, 200);
        n_cmp++;
        if (got_q.size() !== 20) begin
            n_err++;
            $display("FAIL stall_count: got %0d required 20", got_q.size());
        end
        n_cmp++;
        if (err_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL stall_no_drop: err_cnt %0d required 0", err_cnt);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL stall_order: got %h required %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_illegal_cmd();
        int a;
        logic [W-1:0] g;
        send(3'd5, 1'b0, 48'h40, 2'd3, 32'd200, 64'd0, 4'h0, a);
        send(3'd1, 1'b0, 48'h40, 2'd3, 32'd201, 64'd0, 4'h9, a);
        wait_resp(1, 100);
        n_cmp++;
        if (err_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL illegal_err_cnt: got %0d required 1", err_cnt);
        end
        n_cmp++;
        if (got_q.size() !== 1) begin
            n_err++;
            $display("FAIL illegal_count: got %0d required 1", got_q.size());
        end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_cmp++;
            if (g !== {3'd2, 4'h9, 32'd201, 64'hFFFFFFFF_ABFFFFFF}) begin
                n_err++;
                $display("FAIL illegal_resp: got %h required %h", g, {3'd2, 4'h9, 32'd201, 64'hFFFFFFFF_ABFFFFFF});
            end
        end
        got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_flush();
        int a;
        logic [W-1:0] e, g;
        send(3'd2, 1'b0, 48'h100, 2'd3, 32'd301, 64'h01234567_89ABCDEF, 4'h1, a);
        send(3'd2, 1'b0, 48'h108, 2'd3, 32'd302, 64'h11111111_22222222, 4'h2, a);
        send(3'd2, 1'b0, 48'h110, 2'd3, 32'd303, 64'h33333333_44444444, 4'h3, a);
        send(3'd0, 1'b1, 48'h0,   2'd0, 32'd304, 64'd0, 4'hF, a);
        send(3'd1, 1'b0, 48'h108, 2'd3, 32'd305, 64'd0, 4'h4, a);
        exp_q.push_back({3'd3, 4'h1, 32'd301, 64'd0});
        exp_q.push_back({3'd3, 4'h2, 32'd302, 64'd0});
        exp_q.push_back({3'd3, 4'h3, 32'd303, 64'd0});
        exp_q.push_back({3'd4, 4'hF, 32'd304, 64'd0});
        exp_q.push_back({3'd2, 4'h4, 32'd305, 64'h11111111_22222222});
        wait_resp(5, 100);
        n_cmp++;
        if (got_q.size() !== 5) begin
            n_err++;
            $display("FAIL flush_count: got %0d required 5", got_q.size());
        end
        n_cmp++;
        if (err_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL flush_err_cnt: got %0d required 1", err_cnt);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL flush_resp: got %h required %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_reset_inflight();
        int a;
        logic [W-1:0] e, g;
        bus.mc_rs_stall = 1'b1;
        for (int i = 0; i < 4; i++) send(3'd1, 1'b0, 48'h40, 2'd3, 32'(400 + i), 64'd0, 4'h0, a);
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.mc_rs_vld !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_vld: got %b required 1", bus.mc_rs_vld);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mc_rs_vld, bus.mc_rq_stall, err_cnt} !== 18'd0) begin
            n_err++;
            $display("FAIL rst_mid_ctrl: got %h required 0", {bus.mc_rs_vld, bus.mc_rq_stall, err_cnt});
        end
        n_cmp++;
        if ({bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_rtnctl, bus.mc_rs_data} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_payload: got %h required 0",
                     {bus.mc_rs_cmd, bus.mc_rs_scmd, bus.mc_rs_rtnctl, bus.mc_rs_data});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mc_rs_stall = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() !== 0) begin
            n_err++;
            $display("FAIL rst_stale: got %0d responses required 0", got_q.size());
        end
        got_q.delete(); got_cyc_q.delete();
        send(3'd1, 1'b0, 48'h100, 2'd3, 32'd500, 64'd0, 4'h0, a);
        send(3'd1, 1'b0, 48'h40,  2'd3, 32'd501, 64'd0, 4'h0, a);
        exp_q.push_back({3'd2, 4'h0, 32'd500, 64'h01234567_89ABCDEF});
        exp_q.push_back({3'd2, 4'h0, 32'd501, 64'hFFFFFFFF_ABFFFFFF});
        wait_resp(2, 100);
        n_cmp++;
        if (got_q.size() !== 2) begin
            n_err++;
            $display("FAIL rst_after_count: got %0d required 2", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL rst_after_resp: got %h required %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    initial begin
        bus.mc_rq_vld    = 1'b0;
        bus.mc_rq_cmd    = '0;
        bus.mc_rq_scmd   = '0;
        bus.mc_rq_vadr   = '0;
        bus.mc_rq_size   = '0;
        bus.mc_rq_rtnctl = '0;
        bus.mc_rq_data   = '0;
        bus.mc_rq_flush  = 1'b0;
        bus.mc_rs_stall  = 1'b0;
        test_reset();
        test_wr_rd();
        test_byte_lanes();
        test_back_to_back_stall();
        test_illegal_cmd();
        test_flush();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
